// File: rtl/nios2_control_pio_out.sv
// nios2_control_pio_out: Avalon-MM output PIO with set/clear aliases and a counted one-shot pulse.
module nios2_control_pio_out #(
  parameter int          WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic [15:0]      r_cnt;
  logic [15:0]      r_len;
  logic             w_we;
  logic             w_busy;
  logic [WIDTH-1:0] w_wd;
  logic [15:0]      w_len;
  logic [31:0]      w_rd;

  assign w_we     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_busy   = |r_mask;
  assign w_len    = (r_len == 16'd0) ? 16'd1 : r_len;
  assign out_port = r_data | r_mask;

  always_comb begin
    w_rd = '0;
    case (address)
      3'd0:    w_rd = 32'(r_data);
      3'd6:    w_rd = {w_busy, 31'(r_mask)};
      3'd7:    w_rd = 32'(r_len);
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= RESET_VALUE[WIDTH-1:0];
      r_mask   <= '0;
      r_cnt    <= '0;
      r_len    <= 16'd1;
      readdata <= '0;
    end else begin
      readdata <= w_rd;
      if (w_we && address == 3'd0) r_data <= w_wd;
      else if (w_we && address == 3'd4) r_data <= r_data | w_wd;
      else if (w_we && address == 3'd5) r_data <= r_data & ~w_wd;
      if (w_we && address == 3'd7) r_len <= writedata[15:0];
      // a trigger (or retrigger) outranks expiry on the same edge
      if (w_we && address == 3'd6) begin
        r_mask <= w_wd;
        r_cnt  <= (|w_wd) ? w_len : 16'd0;
      end else if (r_cnt == 16'd1) begin
        r_mask <= '0;
        r_cnt  <= '0;
      end else if (r_cnt != 16'd0) begin
        r_cnt  <= r_cnt - 16'd1;
      end
    end
  end
endmodule

// File: doc/nios2_control_pio_out.md
# nios2_control_pio_out

Avalon-MM output PIO for the NIOS2 system. It is the write-direction counterpart of the 4-bit control input PIO. Software drives a 4-bit `out_port` through a data register with atomic set/clear aliases, plus a hardware one-shot that asserts selected bits for a programmed number of clock cycles. It sits on the NIOS2 data master as a 3-bit-address slave with fixed read latency 1.

## Interface
Parameters:
- `WIDTH`, 4: width of `out_port` and of all bit-mask registers (1..31).
- `RESET_VALUE`, 0: value of the data register after reset.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  word address of the register.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; bits above the field width are ignored.
- `readdata`  out  32  registered read data; unused bits read 0.
- `out_port`  out  WIDTH  PIO output.

## Operation
- Write strobe `we` = `chipselect & ~write_n`. At most one write per cycle.
- Register map:
  - 0 `data`, R/W: a write loads `data_reg <= writedata[WIDTH-1:0]`. A read returns `data_reg`, not `out_port`.
  - 1–3: reserved. Reads return 0; writes are ignored.
  - 4 `outset`, W: `data_reg <= data_reg | writedata[WIDTH-1:0]`. Reads return 0.
  - 5 `outclear`, W: `data_reg <= data_reg & ~writedata[WIDTH-1:0]`. Reads return 0.
  - 6 `pulse`, W: triggers the one-shot (see below). A read returns `{busy, 0…, pulse_mask}` with `busy` in bit 31 and `busy = (pulse_mask != 0)`.
  - 7 `pulse_len`, R/W: 16-bit pulse length in `writedata[15:0]`. A read returns it zero-extended.
- `out_port = data_reg | pulse_mask`. This is a combinational OR of two registers.
- One-shot:
  - Effective length `L` = `pulse_len`, or 1 if `pulse_len` is 0.
  - A write to address 6 loads `pulse_mask <= writedata[WIDTH-1:0]`. It loads `cnt <= L` if that mask is nonzero, else `cnt <= 0`.
  - While `cnt != 0`, each edge: if `cnt == 1`, clear `pulse_mask` and set `cnt <= 0`; otherwise `cnt <= cnt - 1`.
  - A write to address 6 while busy is a retrigger: it replaces the mask and reloads the count. On the same edge it takes priority over expiry.
  - Writing `pulse_len` while busy affects only later triggers.
- Read path: every cycle `readdata <= mux(address)`. It is not gated by chipselect or read. This matches the input PIO.

## Timing
- Reset (async assert, any cycle, including mid-pulse):
  - `data_reg = RESET_VALUE`, `pulse_mask = 0`, `cnt = 0`, `pulse_len = 1`.
  - `readdata = 0`, `out_port = RESET_VALUE`.
  - An active pulse aborts immediately.
- Write latency: a write sampled at edge N changes `out_port` in the cycle after edge N.
- Read latency: 1. `address` sampled at edge N appears on `readdata` after edge N.
- Read/write collision: a read of the address being written at the same edge returns the pre-write value. The new value is visible one cycle later.
- Pulse width: a trigger at edge N holds `pulse_mask` from after edge N through edge N+L exclusive. That is exactly L cycles. It is cleared at edge N+L.
- `cnt` is 16 bits. `L` = 65535 gives 65535 cycles with no wrap.
- Pulse bits that are already set in `data_reg` show no visible change on `out_port`. `busy` still reports the pulse.

## Test plan
- Reset with `RESET_VALUE`=4'hA → `out_port`=4'hA, `readdata`=0. Read addr 7 → 1. Read addr 6 → 0.
- Write 0x5 to addr 0, then 0x2 to addr 4, then 0x4 to addr 5 → `out_port` goes 0x5, 0x7, 0x3, each one cycle after its write. Read addr 0 → 0x3. Read addr 4, 5, 1 → 0.
- `pulse_len`=3, `data`=0, write 0x8 to addr 6 at edge N → `out_port`=0x8 for exactly 3 cycles, then 0x0. Read addr 6 during the pulse → 0x80000008. Read after the pulse → 0.
- `pulse_len`=0, pulse 0x1 → 1-cycle pulse. `pulse_len`=5, pulse 0x1, retrigger with 0x2 at the 3rd high cycle → bit0 drops at retrigger+1, bit1 is high for 5 cycles from there.
- `pulse_len`=10, pulse 0xF, assert `reset_n` low at the 4th cycle → `out_port` returns to `RESET_VALUE` asynchronously. After release, `busy`=0 and `pulse_len` reads 1.
- Pulse with mask 0 → `busy` never set, `out_port` unchanged. Write to addr 2 → no state change.
